// File: rtl/pc_pkg.sv
// Shared constants for the PC generator: FSM encodings, increments and default vectors.
// Alignment depends on the PC_COMPRESSED_EN build macro.
package pc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_BOOT = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_TRAP = 2'd2;

    localparam int INC2 = 2;
    localparam int INC4 = 4;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

    // Number of low target bits that must be zero for a legal fetch address
`ifdef PC_COMPRESSED_EN
    localparam int ALIGN = 1;
`else
    localparam int ALIGN = 2;
`endif

endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the pipeline control (master) and the PC generator (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic            trap_ret_i;
    logic            inst_is_16_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic [XLEN-1:0] epc_o;
    logic            misalign_o;
    logic            redirect_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               trap_ret_i, inst_is_16_i,
        input  pc_o, pc_valid_o, epc_o, misalign_o, redirect_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               trap_ret_i, inst_is_16_i,
        output pc_o, pc_valid_o, epc_o, misalign_o, redirect_o
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: priority select, sequential increment and target alignment check.
// With PC_COMPRESSED_EN defined the increment follows inst_is_16_i and 2-byte targets are legal.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_ret_i,
    input  logic            inst_is_16_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] target;

`ifdef PC_COMPRESSED_EN
    assign inc = inst_is_16_i ? XLEN'(INC2) : XLEN'(INC4);
`else
    logic unused_inst_is_16;
    assign unused_inst_is_16 = inst_is_16_i;
    assign inc = XLEN'(INC4);
`endif

    // A redirect request always wins over stall; trap return is never alignment-checked
    always_comb begin
        target     = jump_i ? jump_target_i : branch_target_i;
        next_pc_o  = pc_i + inc;
        redirect_o = 1'b0;
        misalign_o = 1'b0;
        if (trap_ret_i) begin
            next_pc_o  = epc_i;
            redirect_o = 1'b1;
        end else if (jump_i || branch_taken_i) begin
            next_pc_o  = target;
            redirect_o = 1'b1;
            misalign_o = |target[ALIGN-1:0];
        end else if (stall_i) begin
            next_pc_o  = pc_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/TRAP FSM with registered outputs and misaligned-target trap.
// Build macro PC_COMPRESSED_EN enables 2-byte alignment and compressed increments.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC)
) (
    input  logic      clk,
    input  logic      reset_n,
    pc_gen_if.slave   bus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            redirect_q, redirect_d;

    logic [XLEN-1:0] sel_pc;
    logic            sel_redirect;
    logic            sel_misalign;

    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .pc_i            (pc_q),
        .epc_i           (epc_q),
        .stall_i         (bus.stall_i),
        .branch_taken_i  (bus.branch_taken_i),
        .branch_target_i (bus.branch_target_i),
        .jump_i          (bus.jump_i),
        .jump_target_i   (bus.jump_target_i),
        .trap_ret_i      (bus.trap_ret_i),
        .inst_is_16_i    (bus.inst_is_16_i),
        .next_pc_o       (sel_pc),
        .redirect_o      (sel_redirect),
        .misalign_o      (sel_misalign)
    );

    // BOOT and TRAP each last exactly one cycle and leave the PC untouched
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        redirect_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                pc_d       = sel_pc;
                redirect_d = sel_redirect;
                if (sel_misalign) begin
                    pc_d       = TRAP_VEC;
                    epc_d      = pc_q;
                    misalign_d = 1'b1;
                    state_d    = ST_TRAP;
                    valid_d    = 1'b0;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.epc_o      = epc_q;
    assign bus.misalign_o = misalign_q;
    assign bus.redirect_o = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a reference model queues expected outputs per driven cycle.
// Honours PC_COMPRESSED_EN to select the compressed-mode scenarios.
module tb_pc_gen;

    localparam int          XLEN     = 32;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
`ifdef PC_COMPRESSED_EN
    localparam logic [31:0] ALIGN_MASK = 32'h1;
    localparam bit          COMPRESSED = 1'b1;
`else
    localparam logic [31:0] ALIGN_MASK = 32'h3;
    localparam bit          COMPRESSED = 1'b0;
`endif
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_TRAP = 2;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic        mis;
        logic        red;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t expQ[$];
    int   checkCount;
    int   passCount;

    int          mState;
    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic        mValid;
    logic        mMis;
    logic        mRed;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        else
            passCount++;
    endtask

    task automatic modelReset();
        mState = M_BOOT;
        mPc    = 32'h0;
        mEpc   = 32'h0;
        mValid = 1'b0;
        mMis   = 1'b0;
        mRed   = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model and queue the expected post-edge outputs
    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] bt,
                                 input logic jmp, input logic [31:0] jt, input logic tr,
                                 input logic i16);
        logic [31:0] tgt;
        exp_t        e;
        @(negedge clk);
        bus.stall_i         = stall;
        bus.branch_taken_i  = br;
        bus.branch_target_i = bt;
        bus.jump_i          = jmp;
        bus.jump_target_i   = jt;
        bus.trap_ret_i      = tr;
        bus.inst_is_16_i    = i16;
        mMis = 1'b0;
        mRed = 1'b0;
        if (mState == M_RUN) begin
            if (tr) begin
                mPc  = mEpc;
                mRed = 1'b1;
            end else if (jmp || br) begin
                tgt  = jmp ? jt : bt;
                mRed = 1'b1;
                if ((tgt & ALIGN_MASK) != 32'h0) begin
                    mEpc   = mPc;
                    mPc    = TRAP_PC;
                    mMis   = 1'b1;
                    mValid = 1'b0;
                    mState = M_TRAP;
                end else begin
                    mPc = tgt;
                end
            end else if (!stall) begin
                mPc = mPc + ((COMPRESSED && i16) ? 32'd2 : 32'd4);
            end
        end else begin
            mState = M_RUN;
            mValid = 1'b1;
        end
        e.pc = mPc; e.valid = mValid; e.epc = mEpc; e.mis = mMis; e.red = mRed;
        expQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic doJump(input logic [31:0] t);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"},    bus.pc_o,              32'h0);
        checkOutput({tag, "_valid"}, {31'h0, bus.pc_valid_o}, 32'h0);
        checkOutput({tag, "_epc"},   bus.epc_o,             32'h0);
        checkOutput({tag, "_mis"},   {31'h0, bus.misalign_o}, 32'h0);
        checkOutput({tag, "_red"},   {31'h0, bus.redirect_o}, 32'h0);
    endtask

    // Assert reset between edges, check it took effect without a clock, then release after an edge
    task automatic doReset(input string tag);
        #1 reset_n = 1'b0;
        #1 checkResetState(tag);
        modelReset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1 checkResetState({tag, "_boot"});
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("pc",    bus.pc_o,                 e.pc);
            checkOutput("valid", {31'h0, bus.pc_valid_o},  {31'h0, e.valid});
            checkOutput("epc",   bus.epc_o,                e.epc);
            checkOutput("mis",   {31'h0, bus.misalign_o},  {31'h0, e.mis});
            checkOutput("red",   {31'h0, bus.redirect_o},  {31'h0, e.red});
        end
    end

    initial begin
        logic [31:0] bt, jt;
        checkCount = 0;
        passCount  = 0;
        reset_n    = 1'b0;
        bus.stall_i = 1'b0; bus.branch_taken_i = 1'b0; bus.branch_target_i = '0;
        bus.jump_i = 1'b0; bus.jump_target_i = '0; bus.trap_ret_i = 1'b0; bus.inst_is_16_i = 1'b0;
        modelReset();
        #3 checkResetState("rst");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1 checkResetState("boot");

        repeat (4) idle();
        checkOutput("seq_c", bus.pc_o, 32'hC);

        doJump(32'h10);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        checkOutput("jump_over_branch", bus.pc_o, 32'h80);
        idle();
        checkOutput("redirect_once", {31'h0, bus.redirect_o}, 32'h0);

        doJump(32'h20);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("stall_hold", bus.pc_o, 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b0);
        checkOutput("stall_jump", bus.pc_o, 32'h60);

        doJump(32'hFFFF_FFFC);
        idle();
        checkOutput("wrap_pc", bus.pc_o, 32'h0);
        checkOutput("wrap_valid", {31'h0, bus.pc_valid_o}, 32'h1);

`ifdef PC_COMPRESSED_EN
        doJump(32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("c16_inc", bus.pc_o, 32'h6);
        doJump(32'h42);
        checkOutput("c_half_ok", bus.pc_o, 32'h42);
        doJump(32'h43);
        checkOutput("c_trap_pc", bus.pc_o, TRAP_PC);
        doReset("trap_rst");
`else
        doJump(32'h30);
        doJump(32'h42);
        checkOutput("trap_pc", bus.pc_o, TRAP_PC);
        checkOutput("trap_epc", bus.epc_o, 32'h30);
        checkOutput("trap_mis", {31'h0, bus.misalign_o}, 32'h1);
        idle();
        checkOutput("trap_mis_clr", {31'h0, bus.misalign_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("trap_ret", bus.pc_o, 32'h30);
        doJump(32'h42);
        doReset("trap_rst");
`endif
        repeat (2) idle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        doReset("stall_rst");

        for (int i = 0; i < 300; i++) begin
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt = bt & ~32'h3;
            if ($urandom_range(0, 3) != 0) jt = jt & ~32'h3;
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
                          $urandom_range(0, 7) == 0, jt, $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)));
        end

        checkOutput("drain", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
